// File: rtl/esm_pkg.sv
// Shared types and sizing helpers for the out-of-order issue scheduler slice.
package esm_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_WAIT,
        SLOT_ISSUED,
        SLOT_DONE
    } slot_state_e;

    localparam int ESM_DEFAULT_BS = 16;

    function automatic int esm_index_width(input int bs);
        return (bs > 1) ? $clog2(bs) : 1;
    endfunction

endpackage

// File: rtl/esm_age_picker.sv
// Rotating-priority picker: returns the first requesting slot at or after head, wrapping around.
module esm_age_picker
    import esm_pkg::*;
#(
    parameter int  BS = ESM_DEFAULT_BS,
    localparam int IW = esm_index_width(BS)
) (
    input  logic [BS-1:0] req_i,
    input  logic [IW-1:0] head_i,
    output logic          found_o,
    output logic [IW-1:0] index_o
);

    always_comb begin
        found_o = 1'b0;
        index_o = head_i;
        for (int k = 0; k < BS; k++) begin
            if (!found_o && req_i[head_i + IW'(k)]) begin
                found_o = 1'b1;
                index_o = head_i + IW'(k);
            end
        end
    end

endmodule

// File: rtl/esm_issue_scheduler.sv
// Out-of-order issue scheduler: circular slot allocation, dependency wait matrix,
// oldest-first issue, completion wake-up and in-order retirement.
module esm_issue_scheduler
    import esm_pkg::*;
#(
    parameter int  BS = ESM_DEFAULT_BS,
    localparam int IW = esm_index_width(BS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    output logic [IW-1:0] alloc_index,
    input  logic [BS-1:0] idt,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [IW-1:0] issue_index,
    input  logic          complete_valid,
    input  logic [IW-1:0] complete_index,
    output logic          retire_valid,
    output logic [IW-1:0] retire_index,
    output logic [IW:0]   count
);

    slot_state_e   state_q [BS];
    slot_state_e   state_d [BS];
    logic [BS-1:0] wait_q  [BS];
    logic [BS-1:0] wait_d  [BS];

    logic [IW-1:0] head_q, head_d, tail_q, tail_d, cap_idx_q, cap_idx_d;
    logic [IW-1:0] retire_index_q, retire_index_d;
    logic [IW:0]   count_q, count_d;
    logic          cap_pending_q, cap_pending_d, retire_valid_q, retire_valid_d;

    logic          accept, issue_fire, complete_fire, retire_fire;
    logic [BS-1:0] live, ready, done_now;

    always_comb begin
        live  = '0;
        ready = '0;
        for (int i = 0; i < BS; i++) begin
            live[i]  = (state_q[i] == SLOT_WAIT) || (state_q[i] == SLOT_ISSUED);
            ready[i] = (state_q[i] == SLOT_WAIT) && (wait_q[i] == '0)
                       && !(cap_pending_q && (cap_idx_q == IW'(i)));
        end
    end

    esm_age_picker #(.BS(BS)) u_issue_pick (
        .req_i   (ready),
        .head_i  (head_q),
        .found_o (issue_valid),
        .index_o (issue_index)
    );

    assign alloc_ready   = (count_q < (IW+1)'(BS));
    assign alloc_index   = tail_q;
    assign accept        = alloc_valid && alloc_ready;
    assign issue_fire    = issue_valid && issue_ready;
    // A completion only counts against a slot that is actually executing.
    assign complete_fire = complete_valid && (state_q[complete_index] == SLOT_ISSUED);
    assign retire_fire   = (state_q[head_q] == SLOT_DONE);
    assign done_now      = complete_fire ? (BS'(1) << complete_index) : '0;

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        head_d         = head_q;
        tail_d         = tail_q;
        cap_pending_d  = accept;
        cap_idx_d      = accept ? tail_q : cap_idx_q;
        retire_valid_d = retire_fire;
        retire_index_d = retire_fire ? head_q : retire_index_q;
        count_d        = count_q + (IW+1)'(accept) - (IW+1)'(retire_fire);

        if (accept) begin
            state_d[tail_q] = SLOT_WAIT;
            tail_d          = tail_q + IW'(1);
        end
        if (issue_fire) begin
            state_d[issue_index] = SLOT_ISSUED;
        end
        if (complete_fire) begin
            state_d[complete_index] = SLOT_DONE;
            for (int r = 0; r < BS; r++) begin
                wait_d[r][complete_index] = 1'b0;
            end
        end
        // Producers that are free, done, or finishing right now can never block the new row.
        if (cap_pending_q) begin
            wait_d[cap_idx_q] = idt & live & ~(BS'(1) << cap_idx_q) & ~done_now;
        end
        if (retire_fire) begin
            state_d[head_q] = SLOT_FREE;
            head_d          = head_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BS; i++) begin
                state_q[i] <= SLOT_FREE;
                wait_q[i]  <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            cap_idx_q      <= '0;
            cap_pending_q  <= 1'b0;
            retire_valid_q <= 1'b0;
            retire_index_q <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            cap_idx_q      <= cap_idx_d;
            cap_pending_q  <= cap_pending_d;
            retire_valid_q <= retire_valid_d;
            retire_index_q <= retire_index_d;
            count_q        <= count_d;
        end
    end

    assign retire_valid = retire_valid_q;
    assign retire_index = retire_index_q;
    assign count        = count_q;

endmodule

// File: doc/esm_issue_scheduler.md
Name: esm_issue_scheduler

Overview:
- Out-of-order issue scheduler for the instruction buffer whose register-dependency tracker produces a per-slot dependency vector.
- Allocates buffer slots in circular order and drives the slot index to the tracker.
- Captures the returned dependency vector into a BS x BS wait matrix, then issues the oldest ready instruction.
- Clears dependencies on completion; retires slots in program order.

Parameters:
- BS, 16, buffer slots; power of 2, at least 2.
- IW, $clog2(BS), slot index width (derived; not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  dispatcher has a new instruction.
- alloc_ready  out  1  a slot is free; asserted when count < BS.
- alloc_index  out  IW  slot given to the accepted instruction; also drives the tracker's buffer_index.
- idt  in  BS  dependency vector from the tracker; valid the cycle after acceptance.
- issue_valid  out  1  a ready slot exists.
- issue_ready  in  1  execution unit accepts.
- issue_index  out  IW  slot being issued.
- complete_valid  in  1  execution finished.
- complete_index  in  IW  slot that finished.
- retire_valid  out  1  head slot retired this cycle (pulse).
- retire_index  out  IW  retired slot.
- count  out  IW+1  occupied slots.

Behaviour:
- Per-slot state: FREE -> WAIT (on accept) -> ISSUED (on issue handshake) -> DONE (on completion) -> FREE (on retire).
- Reset (sync): all slots FREE; head = tail = 0; count = 0; wait matrix = 0; cap_pending = 0. alloc_ready = 1, alloc_index = 0, issue_valid = 0, retire_valid = 0.
- Allocation:
  - Accept = alloc_valid & alloc_ready. alloc_index = tail.
  - On accept: slot tail -> WAIT; tail += 1 mod BS; cap_pending <= 1; cap_idx <= tail.
  - alloc_ready depends on registered count only. A retire in the same cycle does not make a full buffer accept.
- Capture (cycle after accept):
  - Row cap_idx <= idt & live & ~(1<<cap_idx) & ~done_now.
  - live = slots in WAIT or ISSUED.
  - done_now = one-hot of complete_index when complete_valid this cycle.
  - Bits naming FREE or DONE slots are dropped, so the tracker's post-reset all-ones rows are harmless.
  - A slot with cap_pending set is not issue-eligible.
- Issue:
  - ready[i] = WAIT & row i == 0 & not capture-pending.
  - issue_index = first ready slot scanning head, head+1, ... (oldest first, wrap-around). issue_valid = |ready.
  - Both outputs are combinational from registered state only; no input-to-output path.
  - Handshake issue_valid & issue_ready moves the slot to ISSUED. issue_index must hold while issue_valid is high and issue_ready is low, unless an older slot becomes ready (allowed to change).
- Latency: accept in cycle T -> earliest issue in T+2.
- Completion:
  - complete_valid with slot in ISSUED: slot -> DONE; column complete_index cleared in all rows.
  - Dependents can issue the next cycle.
  - Completion for a slot not in ISSUED is ignored; no state change.
- Retire:
  - If slot head is DONE: retire_valid = 1 (registered pulse the following cycle); slot -> FREE; head += 1.
  - At most one retire per cycle.
- count += accept - retire. Simultaneous accept and retire leaves count unchanged.
- Empty: issue_valid = 0; no retire.
- Full: alloc_ready = 0; tail == head.
- Reset asserted mid-operation: every in-flight slot is discarded and all state reverts to reset values the next cycle, including a pending capture.

Decomposition:
- Shared package esm_pkg holds:
  - slot state enum (FREE, WAIT, ISSUED, DONE);
  - default BS;
  - function clog2-based index width.
- One sub-module: esm_age_picker. Rotating priority picker that takes a BS-bit request vector and a head pointer and returns found plus index, oldest first. Purely combinational and reused by retire logic in later blocks.

Test Plan:
- Reset, then allocate 3 independent instructions (idt = 0 each) with issue_ready = 1 -> issue order 0, 1, 2 at cycles T+2, T+3, T+4; count = 3.
- Slot 1 gets idt = 16'h0001; hold complete for slot 0 until cycle 10 -> slot 1 issues no earlier than cycle 11; slot 2 (idt = 0) issues before slot 1.
- Fill all 16 slots -> alloc_ready = 0 at count = 16. Complete and retire slot 0 -> alloc_ready = 1 next cycle; next alloc_index = 0 (wrap).
- Capture idt = 16'h0004 in the same cycle slot 2 completes -> row bit dropped; dependent issues 1 cycle after capture.
- Complete slots 2 then 0 with head = 0 -> no retire until slot 0 is DONE. Then retire_index 0 and 1 on consecutive cycles if slot 1 is DONE, else only 0.
- Assert rst with 5 slots in flight and a capture pending -> next cycle count = 0, issue_valid = 0, alloc_index = 0.
